// File: rtl/eth_pkg.sv
// Shared types, framing constants and the byte-wide CRC-32 update used by the
// GMII frame transmitter.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HEAD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam int          ETH_HDR_LEN   = 14;
    localparam int          ETH_FCS_LEN   = 4;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reflected-input form: the register holds the CRC bit-reversed, so the
    // polynomial is applied reversed and data enters LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic [31:0] poly_refl;
        poly_refl = bitrev32(CRC32_POLY);
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ poly_refl) : (r >> 1);
        return r;
    endfunction

endpackage

// File: rtl/eth_frame_tx_crc32_d8.sv
// Byte-per-cycle CRC-32 engine; crc_next is the value the register takes at
// the next edge unless clr overrides it.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        gmii_txc,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic [31:0] crc_next
);

    assign crc_next = en ? crc32_byte(crc, data) : crc;

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n)   crc <= CRC32_INIT;
        else if (clr) crc <= CRC32_INIT;
        else          crc <= crc_next;
    end

endmodule

// File: rtl/eth_frame_tx.sv
// GMII Ethernet frame transmitter: preamble/SFD, header, streamed payload,
// zero padding, FCS and inter-frame gap, one frame per accepted tx_start.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC   = 48'h00_11_22_33_44_55,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          PRE_LEN     = 7,
    parameter int          IFG_BYTES   = 12
) (
    input  logic        gmii_txc,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [47:0] tx_dst_mac,
    input  logic [15:0] tx_eth_type,
    input  logic [10:0] tx_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err
);

    state_t       state, state_nxt;
    logic [10:0]  cnt;
    logic [111:0] hdr;
    logic [10:0]  len_r, pad_r;
    logic [10:0]  len_in, pad_in;
    logic         bad_frame;

    logic         en_c, crc_en, done_c, err_c;
    logic [7:0]   byte_c;
    logic [31:0]  crc, crc_nxt, fcs_src, fcs_word;

    crc32_d8 u_crc (
        .gmii_txc (gmii_txc),
        .rst_n    (rst_n),
        .en       (crc_en),
        .clr      (done_c),
        .data     (byte_c),
        .crc      (crc),
        .crc_next (crc_nxt)
    );

    always_comb begin
        len_in = (tx_len > 11'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : tx_len;
        pad_in = (len_in < 11'(MIN_PAYLOAD)) ? 11'(MIN_PAYLOAD) - len_in : 11'd0;
    end

    // Byte 0 needs the value including the last data byte; crc_en is low in
    // FCS so both views agree for the remaining bytes.
    assign fcs_src  = (cnt == 11'd0) ? crc_nxt : crc;
    assign fcs_word = bad_frame ? fcs_src : ~fcs_src;
    assign tx_busy  = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        byte_c    = 8'h00;
        en_c      = 1'b0;
        crc_en    = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
        pl_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) state_nxt = ST_PRE;
            end
            ST_PRE: begin
                en_c = 1'b1;
                if (cnt == 11'(PRE_LEN)) begin
                    byte_c    = ETH_SFD;
                    state_nxt = ST_HEAD;
                end else begin
                    byte_c = ETH_PREAMBLE;
                end
            end
            ST_HEAD: begin
                en_c   = 1'b1;
                crc_en = 1'b1;
                byte_c = hdr[111:104];
                if (cnt == 11'(ETH_HDR_LEN - 1))
                    state_nxt = (len_r != 11'd0) ? ST_PAYLOAD
                              : (pad_r != 11'd0) ? ST_PAD : ST_FCS;
            end
            ST_PAYLOAD: begin
                en_c     = 1'b1;
                crc_en   = 1'b1;
                pl_ready = 1'b1;
                // GMII cannot stall: a missing byte goes out as zero and
                // poisons the FCS.
                byte_c   = pl_valid ? pl_data : 8'h00;
                err_c    = !pl_valid;
                if (cnt == len_r - 11'd1)
                    state_nxt = (pad_r != 11'd0) ? ST_PAD : ST_FCS;
            end
            ST_PAD: begin
                en_c   = 1'b1;
                crc_en = 1'b1;
                if (cnt == pad_r - 11'd1) state_nxt = ST_FCS;
            end
            ST_FCS: begin
                en_c   = 1'b1;
                byte_c = fcs_word[{cnt[1:0], 3'b000} +: 8];
                if (cnt == 11'(ETH_FCS_LEN - 1)) begin
                    done_c    = 1'b1;
                    state_nxt = ST_IFG;
                end
            end
            ST_IFG: begin
                // The IDLE cycle that follows supplies the last gap byte.
                if (cnt == 11'(IFG_BYTES - 2)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= 11'd0;
            hdr        <= '0;
            len_r      <= 11'd0;
            pad_r      <= 11'd0;
            bad_frame  <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= (state_nxt != state) ? 11'd0 : cnt + 11'd1;
            gmii_tx_en <= en_c;
            gmii_txd   <= byte_c;
            tx_done    <= done_c;
            tx_err     <= err_c;
            if (state == ST_IDLE && tx_start) begin
                hdr   <= {tx_dst_mac, BOARD_MAC, tx_eth_type};
                len_r <= len_in;
                pad_r <= pad_in;
            end else if (state == ST_HEAD) begin
                hdr   <= {hdr[103:0], 8'h00};
            end
            if (done_c)     bad_frame <= 1'b0;
            else if (err_c) bad_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: whole expected frames are built from
// the framing rules and a textbook MSB-first CRC-32, then compared bytewise.
`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); end end

module tb_eth_frame_tx;
    import eth_pkg::*;

    typedef logic [7:0] bq_t[$];

    localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

    logic        gmii_txc = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [47:0] tx_dst_mac = '0;
    logic [15:0] tx_eth_type = '0;
    logic [10:0] tx_len = '0;
    logic [7:0]  pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready, gmii_tx_en, tx_busy, tx_done, tx_err;
    logic [7:0]  gmii_txd;

    int checks = 0;
    int errors = 0;

    always #4 gmii_txc = ~gmii_txc;

    eth_frame_tx dut (
        .gmii_txc    (gmii_txc),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .tx_dst_mac  (tx_dst_mac),
        .tx_eth_type (tx_eth_type),
        .tx_len      (tx_len),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = b[31-i];
        return r;
    endfunction

    // Standard CRC-32 value, computed in the non-reflected MSB-first form.
    function automatic logic [31:0] ref_crc(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {rev8(q[i]), 24'h0};
            for (int b = 0; b < 8; b++)
                c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        return ~rev32(c);
    endfunction

    function automatic bq_t build_frame(input logic [47:0] dst, input logic [15:0] et,
                                        input bq_t pay, input int drop);
        bq_t f, body;
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) body.push_back(dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) body.push_back(MAC[8*(5-i) +: 8]);
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        foreach (pay[i]) body.push_back((i == drop) ? 8'h00 : pay[i]);
        while (body.size() < 14 + 46) body.push_back(8'h00);
        fcs = ref_crc(body);
        if (drop >= 0) fcs = ~fcs;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        foreach (body[i]) f.push_back(body[i]);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    task automatic run_frame(input string tag, input logic [47:0] dst, input logic [15:0] et,
                             input int len, input bit seq, input int drop,
                             input bit hold, input bit poke);
        bq_t pay, exp, got;
        int leff, pidx, ndone, nerr, nready, done_at, first_en, t, mis, first_mis, w;
        logic busy1;
        pidx = 0; ndone = 0; nerr = 0; nready = 0; done_at = -1; first_en = -1;
        t = 0; mis = 0; first_mis = -1; busy1 = 1'b0;
        leff = (len > 1500) ? 1500 : len;
        for (int i = 0; i < leff; i++) pay.push_back(seq ? 8'(i) : 8'($urandom));
        exp = build_frame(dst, et, pay, drop);

        @(negedge gmii_txc);
        tx_dst_mac = dst; tx_eth_type = et; tx_len = 11'(len);
        tx_start = 1'b1; pl_valid = 1'b0;
        while (ndone == 0 && t < 3000) begin
            @(negedge gmii_txc);
            t++;
            if (!hold) tx_start = 1'b0;
            if (t == 1) busy1 = tx_busy;
            if (gmii_tx_en) begin
                if (first_en < 0) first_en = t;
                got.push_back(gmii_txd);
            end
            if (tx_err) nerr++;
            if (tx_done) begin ndone++; done_at = got.size(); end
            if (poke) begin
                tx_start   = (nready == 3) && pl_ready;
                tx_dst_mac = 48'({$urandom, $urandom});
                tx_len     = 11'($urandom);
            end
            if (pl_ready) begin
                nready++;
                pl_valid = (pidx != drop);
                pl_data  = (pl_valid && pidx < pay.size()) ? pay[pidx] : 8'($urandom);
                pidx++;
            end else begin
                pl_valid = 1'($urandom);
                pl_data  = 8'($urandom);
            end
        end

        for (int i = 0; i < got.size() && i < exp.size(); i++)
            if (got[i] !== exp[i]) begin
                mis++;
                if (first_mis < 0) first_mis = i;
            end
        `CHK({tag, ".tx_en_cycles"}, got.size(), exp.size())
        `CHK({tag, ".byte_mismatches(first_idx_in_note)"}, mis, 0)
        if (first_mis >= 0)
            $display("note %s first differing byte %0d: %0h vs %0h", tag, first_mis,
                     got[first_mis], exp[first_mis]);
        `CHK({tag, ".done_pulses"}, ndone, 1)
        `CHK({tag, ".done_on_last_byte"}, done_at, exp.size())
        `CHK({tag, ".err_pulses"}, nerr, (drop >= 0 && drop < leff) ? 1 : 0)
        `CHK({tag, ".ready_cycles"}, nready, leff)
        `CHK({tag, ".busy_after_start"}, busy1, 1'b1)
        `CHK({tag, ".start_latency"}, first_en, 2)

        if (!hold) begin
            w = 0;
            while (tx_busy && w < 40) begin @(negedge gmii_txc); w++; end
            `CHK({tag, ".busy_released"}, tx_busy, 1'b0)
        end
    endtask

    initial begin
        int acc, gap, w;

        // Reset with random inputs
        repeat (3) begin
            @(negedge gmii_txc);
            tx_start = 1'($urandom); tx_dst_mac = 48'({$urandom, $urandom});
            tx_eth_type = 16'($urandom); tx_len = 11'($urandom);
            pl_data = 8'($urandom); pl_valid = 1'($urandom);
        end
        `CHK("reset.outputs", {gmii_tx_en, gmii_txd, tx_busy, tx_done, tx_err, pl_ready}, 13'h0)
        @(negedge gmii_txc);
        tx_start = 1'b0;
        rst_n = 1'b1;
        acc = 0;
        repeat (20) begin
            @(negedge gmii_txc);
            acc += int'(gmii_tx_en) + int'(tx_busy) + int'(tx_done);
            pl_valid = 1'($urandom); tx_len = 11'($urandom);
        end
        `CHK("idle.no_activity", acc, 0)

        run_frame("arp", 48'hFFFF_FFFF_FFFF, ETH_TYPE_ARP, 28, 1'b0, -1, 1'b0, 1'b0);
        run_frame("long", 48'({$urandom, $urandom}), ETH_TYPE_IPV4, 64, 1'b1, -1, 1'b0, 1'b0);
        run_frame("underflow", 48'({$urandom, $urandom}), 16'($urandom), 40, 1'b0, 5, 1'b0, 1'b0);
        run_frame("min46", 48'({$urandom, $urandom}), ETH_TYPE_IPV4, 46, 1'b0, -1, 1'b0, 1'b0);
        run_frame("len45", 48'({$urandom, $urandom}), ETH_TYPE_IPV4, 45, 1'b0, -1, 1'b0, 1'b0);
        run_frame("len0", 48'({$urandom, $urandom}), 16'($urandom), 0, 1'b0, -1, 1'b0, 1'b0);
        run_frame("clamp", 48'({$urandom, $urandom}), ETH_TYPE_IPV4, 1600, 1'b0, -1, 1'b0, 1'b0);

        // tx_start pulsed mid-payload must not alter or requeue a frame
        run_frame("poke", 48'({$urandom, $urandom}), ETH_TYPE_IPV4, 50, 1'b0, -1, 1'b0, 1'b1);
        tx_start = 1'b0;
        acc = 0;
        repeat (20) begin @(negedge gmii_txc); acc += int'(gmii_tx_en); end
        `CHK("poke.not_queued", acc, 0)

        // Back-to-back with tx_start held
        run_frame("b2b", 48'({$urandom, $urandom}), ETH_TYPE_ARP, 0, 1'b0, -1, 1'b1, 1'b0);
        gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge gmii_txc);
            if (gmii_tx_en) break;
            gap++;
        end
        tx_start = 1'b0;
        `CHK("b2b.ifg_cycles", gap, 12)
        w = 0;
        while (tx_busy && w < 200) begin @(negedge gmii_txc); w++; end
        `CHK("b2b.second_done", tx_busy, 1'b0)

        // Reset asserted in PAYLOAD
        @(negedge gmii_txc);
        tx_len = 11'd28; tx_start = 1'b1;
        @(negedge gmii_txc);
        tx_start = 1'b0;
        w = 0; acc = 0;
        while (acc < 3 && w < 100) begin
            @(negedge gmii_txc);
            w++;
            if (pl_ready) acc++;
            pl_valid = 1'b1; pl_data = 8'($urandom);
        end
        `CHK("midrst.reached_payload", acc, 3)
        rst_n = 1'b0;
        #1;
        `CHK("midrst.async_drop", {gmii_tx_en, tx_busy, pl_ready}, 3'b000)
        @(negedge gmii_txc);
        rst_n = 1'b1;
        pl_valid = 1'b0;
        run_frame("post_rst", 48'hFFFF_FFFF_FFFF, ETH_TYPE_ARP, 28, 1'b0, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
